// File: rtl/seg7_pkg.sv
// Shared 7-segment codes and patterns for the lock display path.
// Patterns are active-high, bit order {g,f,e,d,c,b,a}.
package seg7_pkg;

  localparam logic [4:0] CODE_0     = 5'd0;
  localparam logic [4:0] CODE_1     = 5'd1;
  localparam logic [4:0] CODE_2     = 5'd2;
  localparam logic [4:0] CODE_3     = 5'd3;
  localparam logic [4:0] CODE_4     = 5'd4;
  localparam logic [4:0] CODE_5     = 5'd5;
  localparam logic [4:0] CODE_6     = 5'd6;
  localparam logic [4:0] CODE_7     = 5'd7;
  localparam logic [4:0] CODE_8     = 5'd8;
  localparam logic [4:0] CODE_9     = 5'd9;
  localparam logic [4:0] CODE_A     = 5'd10;
  localparam logic [4:0] CODE_B     = 5'd11;
  localparam logic [4:0] CODE_C     = 5'd12;
  localparam logic [4:0] CODE_D     = 5'd13;
  localparam logic [4:0] CODE_E     = 5'd14;
  localparam logic [4:0] CODE_F     = 5'd15;
  localparam logic [4:0] CODE_BLANK = 5'd16;
  localparam logic [4:0] CODE_DASH  = 5'd17;
  localparam logic [4:0] CODE_L     = 5'd18;
  localparam logic [4:0] CODE_LO_O  = 5'd19;
  localparam logic [4:0] CODE_P     = 5'd20;
  localparam logic [4:0] CODE_LO_N  = 5'd21;
  localparam logic [4:0] CODE_LO_R  = 5'd22;
  localparam logic [4:0] CODE_H     = 5'd23;
  localparam logic [4:0] CODE_U     = 5'd24;
  localparam logic [4:0] CODE_LO_T  = 5'd25;
  localparam logic [4:0] CODE_LO_Y  = 5'd26;
  localparam logic [4:0] CODE_J     = 5'd27;
  localparam logic [4:0] CODE_UNDER = 5'd28;
  localparam logic [4:0] CODE_OVER  = 5'd29;
  localparam logic [4:0] CODE_DEG   = 5'd30;
  localparam logic [4:0] CODE_LAMP  = 5'd31;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_A     = 7'h77;
  localparam logic [6:0] SEG_B     = 7'h7C;
  localparam logic [6:0] SEG_C     = 7'h39;
  localparam logic [6:0] SEG_D     = 7'h5E;
  localparam logic [6:0] SEG_E     = 7'h79;
  localparam logic [6:0] SEG_F     = 7'h71;
  localparam logic [6:0] SEG_BLANK = 7'h00;
  localparam logic [6:0] SEG_DASH  = 7'h40;
  localparam logic [6:0] SEG_L     = 7'h38;
  localparam logic [6:0] SEG_LO_O  = 7'h5C;
  localparam logic [6:0] SEG_P     = 7'h73;
  localparam logic [6:0] SEG_LO_N  = 7'h54;
  localparam logic [6:0] SEG_LO_R  = 7'h50;
  localparam logic [6:0] SEG_H     = 7'h76;
  localparam logic [6:0] SEG_U     = 7'h3E;
  localparam logic [6:0] SEG_LO_T  = 7'h78;
  localparam logic [6:0] SEG_LO_Y  = 7'h6E;
  localparam logic [6:0] SEG_J     = 7'h1E;
  localparam logic [6:0] SEG_UNDER = 7'h08;
  localparam logic [6:0] SEG_OVER  = 7'h01;
  localparam logic [6:0] SEG_DEG   = 7'h63;
  localparam logic [6:0] SEG_LAMP  = 7'h7F;

endpackage

// File: rtl/binary_to_segment.sv
// Registered 5-bit code to 7-segment decoder, one cycle latency.
// Board polarity is applied once at the output register.
module binary_to_segment
  import seg7_pkg::*;
#(
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] seven_in,
  output logic [6:0] seven_out
);

  localparam logic [6:0] SEG_OFF =
    ACTIVE_LOW ? 7'h7F : 7'h00;

  logic [6:0] seg_d;
  logic [6:0] seg_pol_d;
  logic [6:0] seven_q;

  // Active-high glyph lookup over every code.
  always_comb begin
    seg_d = SEG_BLANK;
    unique case (seven_in)
      CODE_0:     seg_d = SEG_0;
      CODE_1:     seg_d = SEG_1;
      CODE_2:     seg_d = SEG_2;
      CODE_3:     seg_d = SEG_3;
      CODE_4:     seg_d = SEG_4;
      CODE_5:     seg_d = SEG_5;
      CODE_6:     seg_d = SEG_6;
      CODE_7:     seg_d = SEG_7;
      CODE_8:     seg_d = SEG_8;
      CODE_9:     seg_d = SEG_9;
      CODE_A:     seg_d = SEG_A;
      CODE_B:     seg_d = SEG_B;
      CODE_C:     seg_d = SEG_C;
      CODE_D:     seg_d = SEG_D;
      CODE_E:     seg_d = SEG_E;
      CODE_F:     seg_d = SEG_F;
      CODE_BLANK: seg_d = SEG_BLANK;
      CODE_DASH:  seg_d = SEG_DASH;
      CODE_L:     seg_d = SEG_L;
      CODE_LO_O:  seg_d = SEG_LO_O;
      CODE_P:     seg_d = SEG_P;
      CODE_LO_N:  seg_d = SEG_LO_N;
      CODE_LO_R:  seg_d = SEG_LO_R;
      CODE_H:     seg_d = SEG_H;
      CODE_U:     seg_d = SEG_U;
      CODE_LO_T:  seg_d = SEG_LO_T;
      CODE_LO_Y:  seg_d = SEG_LO_Y;
      CODE_J:     seg_d = SEG_J;
      CODE_UNDER: seg_d = SEG_UNDER;
      CODE_OVER:  seg_d = SEG_OVER;
      CODE_DEG:   seg_d = SEG_DEG;
      CODE_LAMP:  seg_d = SEG_LAMP;
      default:    seg_d = SEG_BLANK;
    endcase
  end

  // Board polarity: lit segment drives 0 on common anode.
  always_comb begin
    seg_pol_d = ACTIVE_LOW ? ~seg_d : seg_d;
  end

  // Output register; reset blanks the digit.
  always_ff @(posedge clk) begin
    if (reset) seven_q <= SEG_OFF;
    else       seven_q <= seg_pol_d;
  end

  assign seven_out = seven_q;

endmodule

// File: tb/tb_binary_to_segment.sv
// Directed check of the registered segment decoder,
// both polarities, latency and reset priority.
module tb_binary_to_segment;

  typedef struct {
    logic [4:0] code;
    logic [6:0] exp;
  } vec_t;

  logic       clk;
  logic       reset;
  logic [4:0] seven_in;
  logic [6:0] out_lo;
  logic [6:0] out_hi;

  int n_vec;
  int n_bad;

  vec_t tbl [32];

  binary_to_segment #(.ACTIVE_LOW(1'b1)) dut_lo (
    .clk       (clk),
    .reset     (reset),
    .seven_in  (seven_in),
    .seven_out (out_lo)
  );

  binary_to_segment #(.ACTIVE_LOW(1'b0)) dut_hi (
    .clk       (clk),
    .reset     (reset),
    .seven_in  (seven_in),
    .seven_out (out_hi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [6:0] act,
                     input logic [6:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    tbl[0]  = '{5'd0,  7'h40};
    tbl[1]  = '{5'd1,  7'h79};
    tbl[2]  = '{5'd2,  7'h24};
    tbl[3]  = '{5'd3,  7'h30};
    tbl[4]  = '{5'd4,  7'h19};
    tbl[5]  = '{5'd5,  7'h12};
    tbl[6]  = '{5'd6,  7'h02};
    tbl[7]  = '{5'd7,  7'h78};
    tbl[8]  = '{5'd8,  7'h00};
    tbl[9]  = '{5'd9,  7'h10};
    tbl[10] = '{5'd10, 7'h08};
    tbl[11] = '{5'd11, 7'h03};
    tbl[12] = '{5'd12, 7'h46};
    tbl[13] = '{5'd13, 7'h21};
    tbl[14] = '{5'd14, 7'h06};
    tbl[15] = '{5'd15, 7'h0E};
    tbl[16] = '{5'd16, 7'h7F};
    tbl[17] = '{5'd17, 7'h3F};
    tbl[18] = '{5'd18, 7'h47};
    tbl[19] = '{5'd19, 7'h23};
    tbl[20] = '{5'd20, 7'h0C};
    tbl[21] = '{5'd21, 7'h2B};
    tbl[22] = '{5'd22, 7'h2F};
    tbl[23] = '{5'd23, 7'h09};
    tbl[24] = '{5'd24, 7'h41};
    tbl[25] = '{5'd25, 7'h07};
    tbl[26] = '{5'd26, 7'h11};
    tbl[27] = '{5'd27, 7'h61};
    tbl[28] = '{5'd28, 7'h77};
    tbl[29] = '{5'd29, 7'h7E};
    tbl[30] = '{5'd30, 7'h1C};
    tbl[31] = '{5'd31, 7'h00};

    // reset held two cycles with code 8 presented
    reset    = 1'b1;
    seven_in = 5'd8;
    tick();
    chk("rst1_lo", out_lo, 7'h7F);
    chk("rst1_hi", out_hi, 7'h00);
    tick();
    chk("rst2_lo", out_lo, 7'h7F);
    chk("rst2_hi", out_hi, 7'h00);
    reset = 1'b0;
    tick();
    chk("rel_lo", out_lo, 7'h00);
    chk("rel_hi", out_hi, 7'h7F);

    // full table sweep; output must hold until the edge
    for (int i = 0; i < 32; i++) begin
      seven_in = tbl[i].code;
      #1;
      if (i > 0) chk("hold", out_lo, tbl[i-1].exp);
      tick();
      chk($sformatf("lo_%0d", i), out_lo, tbl[i].exp);
      chk($sformatf("hi_%0d", i), out_hi,
          7'h7F ^ tbl[i].exp);
    end

    // back-to-back alternation 1/7
    for (int i = 0; i < 8; i++) begin
      seven_in = (i % 2 == 0) ? 5'd1 : 5'd7;
      tick();
      chk("alt", out_lo, (i % 2 == 0) ? 7'h79 : 7'h78);
    end

    // reset on the same edge the code changes to 3
    seven_in = 5'd1;
    tick();
    chk("pre_rst", out_lo, 7'h79);
    reset    = 1'b1;
    seven_in = 5'd3;
    tick();
    chk("mid_rst_lo", out_lo, 7'h7F);
    chk("mid_rst_hi", out_hi, 7'h00);
    reset = 1'b0;
    tick();
    chk("post_rst_lo", out_lo, 7'h30);
    chk("post_rst_hi", out_hi, 7'h4F);

    // inverted polarity build: code 1
    seven_in = 5'd1;
    tick();
    chk("pol_1", out_hi, 7'h06);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
